uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the core's data bus. It turns byte stores to the console address into 8N1 serial frames on `uart_out`. It sits beside data memory in `top`, decoded from the same `wen`/`addr_d`/`wdata` signals the core drives in its write-back state. It buffers bytes in a small FIFO so the core never stalls on a single character, and exposes a status register for software polling.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200); must be ≥2.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, ≥2.
- `BASE_ADDR`, default 32'h1000: TXDATA address; STATUS is at `BASE_ADDR+4`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `wen`  in  1  bus write strobe, one cycle per store.
- `ren`  in  1  bus read strobe.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data; TXDATA uses only `[7:0]`.
- `intr`  in  1  core is in trap entry; while high, writes are ignored.
- `rdata`  out  32  combinational read data; zero unless `ren` is high and `addr==BASE_ADDR+4`.
- `tx_busy`  out  1  high when the FIFO is non-empty or a frame is in flight.
- `uart_out`  out  1  serial line; idles high.

## Operation
- **Push.** A push happens when `wen & !intr & addr==BASE_ADDR`. `wdata[7:0]` enters the FIFO at that edge.
- **Full FIFO.** If the FIFO is full at the start of the cycle, the push is dropped and sticky `ovf` is set. This applies even if a pop happens in the same cycle.
- **STATUS read layout.**
  - bit0 = `tx_busy`
  - bit1 = FIFO full
  - bit2 = `ovf`
  - bits[5:3] = FIFO count (saturating to 7)
  - other bits 0.
- **STATUS write.** Writing STATUS with `wdata[2]=1` clears `ovf`. If a drop happens in the same cycle, set wins.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into `shreg`, go to START, drive `uart_out=0`.
  - START: after `CLKS_PER_BIT` cycles, go to DATA with `bit_idx=0`.
  - DATA: drive `shreg[bit_idx]`, LSB first. Each bit lasts `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: drive 1 for `CLKS_PER_BIT` cycles. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Output register.** `uart_out` is driven from a flop; it is never combinational.
- **Counters.**
  - Bit-period counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
  - The count register is one bit wider than the pointers.
- **Reset values** (asserting `rst_n` low mid-frame aborts the frame and returns the line high immediately):
  - `uart_out=1`, `tx_busy=0`, FSM=IDLE
  - FIFO empty, `ovf=0`, counters 0.

## Timing
- **First frame latency.** With a push at edge k into an empty FIFO in IDLE:
  - count=1 after k
  - pop at edge k+1; `uart_out` falls after k+1
  - start bit covers edges k+1..k+`CLKS_PER_BIT`.
- **Frame length.** Exactly `10*CLKS_PER_BIT` cycles, start edge to end of stop.
- **Back-to-back frames.** The next start bit begins on the edge the previous stop bit ends.
- **Same-cycle push and pop.** A push in the same cycle as a pop (not full) leaves the count unchanged, and the data is preserved in order.
- **`tx_busy`.**
  - Rises after the push edge.
  - Falls after the edge that ends the last stop bit with an empty FIFO.
- **`rdata`.** Reflects state registered at the previous edge.

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef (`TX_IDLE`, `TX_START`, `TX_DATA`, `TX_STOP`, 2-bit)
  - register offsets (`UART_TXDATA_OFS=0`, `UART_STATUS_OFS=4`)
  - STATUS bit indices.
- One sub-module `sync_fifo` (parameters `WIDTH=8`, `DEPTH`):
  - push/pop/full/empty/count.
  - A pop on empty is ignored.
  - Reusable for a future `uart_rx_mmio`.

## Test plan
Directed scenarios use `CLKS_PER_BIT=4` and `FIFO_DEPTH=4`.
- **Reset.** Hold `rst_n=0` for 2 cycles, release → `uart_out=1`, `tx_busy=0`, STATUS read = 0.
- **Single byte.** Write 0x41 to 0x1000 → line reads 0,1,0,0,0,0,0,1,0,1, each held 4 cycles. The start bit falls 1 edge after the write. `tx_busy` drops 40 cycles after the start.
- **Back-to-back.** Write "Hi\n" in 3 consecutive cycles → three 40-cycle frames with no gap. A bench monitor decodes "Hi\n".
- **Overflow.** Write 6 bytes in 6 consecutive cycles → 5 are transmitted (one pops at the second edge), the 6th is dropped, STATUS bit2=1. Writing 0x4 to 0x1004 clears it.
- **Intr gating and decode.** A write to 0x1000 with `intr=1`, and a write to 0x1008, produce no frame and leave count=0.
- **Reset mid-frame.** Assert `rst_n` low during data bit 3 → `uart_out=1` asynchronously. The FIFO is empty after release, and no partial frame resumes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register map for the console UART blocks.
// Holds the TX FSM encoding, register offsets and STATUS bit positions.
package uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   localparam logic [31:0] UART_TXDATA_OFS = 32'h0;
   localparam logic [31:0] UART_STATUS_OFS = 32'h4;

   localparam int ST_BUSY = 0;
   localparam int ST_FULL = 1;
   localparam int ST_OVF  = 2;
   localparam int ST_CNT  = 3;

   function automatic logic [2:0] sat3(input logic [31:0] v);
      return (v > 32'd7) ? 3'd7 : v[2:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count.
// Push on full and pop on empty are silently ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and STATUS register.
// Byte stores to TXDATA are queued; STATUS supports polling and ovf clear.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wen,
   input  logic        ren,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        intr,
   output logic [31:0] rdata,
   output logic        tx_busy,
   output logic        uart_out
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam int          CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [31:0] TX_ADDR = BASE_ADDR + UART_TXDATA_OFS;
   localparam logic [31:0] ST_ADDR = BASE_ADDR + UART_STATUS_OFS;

   logic          wr_ok;
   logic          push;
   logic          stat_wr;
   logic          drop;
   logic          ovf;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_data;
   logic [AW:0]   fifo_count;

   tx_state_e     state;
   tx_state_e     state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_nxt;
   logic [7:0]    shreg;
   logic [7:0]    shreg_nxt;
   logic          line;
   logic          line_nxt;
   logic          bit_end;
   logic [31:0]   status;
   logic          unused_wdata;

   assign unused_wdata = ^{wdata[31:8], wdata[1:0]};

   assign wr_ok   = wen & ~intr;
   assign push    = wr_ok & (addr == TX_ADDR);
   assign stat_wr = wr_ok & (addr == ST_ADDR);
   assign drop    = push & fifo_full;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (wdata[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A drop in the same cycle as a clear keeps ovf set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (stat_wr & wdata[2]) begin
         ovf <= 1'b0;
      end
   end

   assign bit_end = (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= TX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         line    <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         shreg   <= shreg_nxt;
         line    <= line_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      line_nxt  = line;
      fifo_pop  = 1'b0;
      unique case (state)
         TX_IDLE: begin
            cnt_nxt = '0;
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shreg_nxt = fifo_data;
               line_nxt  = 1'b0;
               state_nxt = TX_START;
            end
         end
         TX_START: begin
            cnt_nxt = cnt + CW'(1);
            if (bit_end) begin
               cnt_nxt   = '0;
               bit_nxt   = '0;
               line_nxt  = shreg[0];
               state_nxt = TX_DATA;
            end
         end
         TX_DATA: begin
            cnt_nxt = cnt + CW'(1);
            if (bit_end) begin
               cnt_nxt = '0;
               if (bit_idx == 3'd7) begin
                  line_nxt  = 1'b1;
                  state_nxt = TX_STOP;
               end else begin
                  bit_nxt  = bit_idx + 3'd1;
                  line_nxt = shreg[bit_idx + 3'd1];
               end
            end
         end
         TX_STOP: begin
            cnt_nxt = cnt + CW'(1);
            if (bit_end) begin
               cnt_nxt = '0;
               // Chain straight into the next start bit when data waits.
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  shreg_nxt = fifo_data;
                  line_nxt  = 1'b0;
                  state_nxt = TX_START;
               end else begin
                  line_nxt  = 1'b1;
                  state_nxt = TX_IDLE;
               end
            end
         end
         default: begin
            state_nxt = TX_IDLE;
         end
      endcase
   end

   assign tx_busy  = ~fifo_empty | (state != TX_IDLE);
   assign uart_out = line;

   always_comb begin
      status                       = '0;
      status[ST_BUSY]              = tx_busy;
      status[ST_FULL]              = fifo_full;
      status[ST_OVF]               = ovf;
      status[ST_CNT+2:ST_CNT]      = sat3(32'(fifo_count));
   end

   assign rdata = (ren && (addr == ST_ADDR)) ? status : 32'd0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with a serial decoder on uart_out.
// Uses CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_uart_tx_mmio;

   localparam int CPB = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        wen   = 1'b0;
   logic        ren   = 1'b0;
   logic        intr  = 1'b0;
   logic [31:0] addr  = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        tx_busy;
   logic        uart_out;

   int total = 0;
   int bad   = 0;

   logic [7:0] rx_q [$];
   logic [7:0] mb;
   logic       mok;

   typedef struct {
      logic [31:0] a;
      logic        irq;
      logic [7:0]  d;
      logic        push;
      logic [31:0] st;
   } vec_t;

   vec_t vt [6];
   logic fb [10];

   always #5 clk = ~clk;

   uart_tx_mmio #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4),
      .BASE_ADDR    (32'h1000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wen      (wen),
      .ren      (ren),
      .addr     (addr),
      .wdata    (wdata),
      .intr     (intr),
      .rdata    (rdata),
      .tx_busy  (tx_busy),
      .uart_out (uart_out)
   );

   // Serial decoder: samples each bit CPB cycles after the start fall.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rst_n && uart_out === 1'b0) begin
            mok = 1'b1;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(posedge clk);
               #2;
               mb[i] = uart_out;
               if (!rst_n) mok = 1'b0;
            end
            repeat (CPB) @(posedge clk);
            #2;
            if (!rst_n || uart_out !== 1'b1) mok = 1'b0;
            if (mok) rx_q.push_back(mb);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic irq);
      wen   = 1'b1;
      addr  = a;
      wdata = d;
      intr  = irq;
      @(posedge clk);
      #1;
      wen   = 1'b0;
      intr  = 1'b0;
      addr  = 32'd0;
      wdata = 32'd0;
   endtask

   task automatic rd_status(output logic [31:0] v);
      ren  = 1'b1;
      addr = 32'h1004;
      #1;
      v    = rdata;
      ren  = 1'b0;
      addr = 32'd0;
   endtask

   task automatic wait_idle(input int lim, output int n);
      n = 0;
      while (tx_busy && n < lim) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_wait", {31'd0, tx_busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] st;
      int          n;
      int          lows;

      vt[0] = '{32'h1000, 1'b1, 8'h55, 1'b0, 32'h00};
      vt[1] = '{32'h1008, 1'b0, 8'h55, 1'b0, 32'h00};
      vt[2] = '{32'h1001, 1'b0, 8'h66, 1'b0, 32'h00};
      vt[3] = '{32'h1004, 1'b0, 8'h04, 1'b0, 32'h00};
      vt[4] = '{32'h0000, 1'b0, 8'h77, 1'b0, 32'h00};
      vt[5] = '{32'h1000, 1'b0, 8'h5A, 1'b1, 32'h09};
      fb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      // Reset
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_line", {31'd0, uart_out}, 32'd1);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      rd_status(st);
      check("rst_status", st, 32'd0);

      // Single byte 0x41
      rx_q.delete();
      wr(32'h1000, 32'h41, 1'b0);
      check("sb_busy_rise", {31'd0, tx_busy}, 32'd1);
      check("sb_line_before", {31'd0, uart_out}, 32'd1);
      rd_status(st);
      check("sb_status", st, 32'h09);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("sb_bit%0d", i), {31'd0, uart_out},
               {31'd0, fb[i/CPB]});
         check($sformatf("sb_busy%0d", i), {31'd0, tx_busy}, 32'd1);
      end
      @(posedge clk);
      #1;
      check("sb_busy_fall", {31'd0, tx_busy}, 32'd0);
      check("sb_line_idle", {31'd0, uart_out}, 32'd1);
      check("sb_rx_n", rx_q.size(), 32'd1);
      if (rx_q.size() > 0) check("sb_rx_byte", {24'd0, rx_q[0]}, 32'h41);

      // Back-to-back "Hi\n"
      rx_q.delete();
      wr(32'h1000, 32'h48, 1'b0);
      wr(32'h1000, 32'h69, 1'b0);
      wr(32'h1000, 32'h0A, 1'b0);
      wait_idle(400, n);
      check("b2b_cycles", n, 32'd119);
      check("b2b_rx_n", rx_q.size(), 32'd3);
      if (rx_q.size() == 3) begin
         check("b2b_rx0", {24'd0, rx_q[0]}, 32'h48);
         check("b2b_rx1", {24'd0, rx_q[1]}, 32'h69);
         check("b2b_rx2", {24'd0, rx_q[2]}, 32'h0A);
      end

      // Overflow: six stores, one drained at the second edge, sixth dropped
      rx_q.delete();
      for (int i = 0; i < 6; i++) begin
         wr(32'h1000, 32'h31 + i, 1'b0);
      end
      rd_status(st);
      check("ovf_status", st, 32'h27);
      addr = 32'h1004;
      #1;
      check("ovf_no_ren", rdata, 32'd0);
      addr = 32'd0;
      wr(32'h1004, 32'h4, 1'b0);
      rd_status(st);
      check("ovf_cleared", st, 32'h23);
      wait_idle(400, n);
      check("ovf_rx_n", rx_q.size(), 32'd5);
      if (rx_q.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            check($sformatf("ovf_rx%0d", i), {24'd0, rx_q[i]}, 32'h31 + i);
         end
      end

      // Decode and intr gating table
      for (int v = 0; v < 6; v++) begin
         rx_q.delete();
         wr(vt[v].a, {24'd0, vt[v].d}, vt[v].irq);
         rd_status(st);
         check($sformatf("vec%0d_status", v), st, vt[v].st);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_line", v), {31'd0, uart_out},
               {31'd0, ~vt[v].push});
         if (vt[v].push) begin
            wait_idle(100, n);
            check($sformatf("vec%0d_rx_n", v), rx_q.size(), 32'd1);
            if (rx_q.size() == 1) begin
               check($sformatf("vec%0d_rx", v), {24'd0, rx_q[0]},
                     {24'd0, vt[v].d});
            end
         end else begin
            check($sformatf("vec%0d_busy", v), {31'd0, tx_busy}, 32'd0);
         end
      end

      // Reset during data bit 3
      rx_q.delete();
      wr(32'h1000, 32'h00, 1'b0);
      wr(32'h1000, 32'h77, 1'b0);
      repeat (17) @(posedge clk);
      #1;
      check("mr_bit3_low", {31'd0, uart_out}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("mr_line_async", {31'd0, uart_out}, 32'd1);
      check("mr_busy_async", {31'd0, tx_busy}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd_status(st);
      check("mr_status", st, 32'd0);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (uart_out !== 1'b1) lows++;
      end
      check("mr_no_resume", lows, 32'd0);
      check("mr_rx_n", rx_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
